// File: rtl/clkmon_pkg.sv
// Shared definitions for the clk_period_meter slice: FSM state encoding,
// default counter width and averaging depth.
package clkmon_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LOST       = 2'd2
  } state_e;

endpackage

// File: rtl/clkmon_sync.sv
// Brings the asynchronous clk_in into the mclk domain and turns its edges
// into registered single-cycle rise/fall strobes.
module clkmon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic clk_in,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // NOTE: every flop in the chain uses <= so each stage samples the previous
  // stage's old value; blocking assignments would collapse the chain.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_in};
      hist_q     <= sync_lvl;
      rise_pulse <= sync_lvl & ~hist_q;
      fall_pulse <= ~sync_lvl & hist_q;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in mclk cycles and flags loss
// of clock. Define CLKMON_AVG_EN to report a 4-period moving average instead.
module clk_period_meter
  import clkmon_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = '1
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             clk_lost
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             at_timeout;

  clkmon_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .clk_in    (clk_in),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  assign at_timeout = (cnt == TIMEOUT);

  // Restarts at 1 on every rise and parks at TIMEOUT rather than wrapping, so
  // a stopped clock can never alias into a plausible period.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise_pulse) begin
      cnt <= ONE;
    end else if (!at_timeout) begin
      cnt <= cnt + ONE;
    end
  end

`ifdef CLKMON_AVG_EN
  localparam int ACC_W = CNT_W + 2;
  localparam int CAP_W = $clog2(AVG_DEPTH + 1);

  logic [CNT_W-1:0] avg_hist [AVG_DEPTH];
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CAP_W-1:0] cap_cnt;

  // Running sum: add the newest raw period, drop the one leaving the window.
  assign acc_sum = acc_q + ACC_W'(cnt) - ACC_W'(avg_hist[AVG_DEPTH-1]);
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_FIRST;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      clk_lost     <= 1'b0;
`ifdef CLKMON_AVG_EN
      acc_q        <= '0;
      cap_cnt      <= '0;
      // NOTE: the history is reset explicitly because stale entries would
      // leak into the first averages; plain data memories need no reset.
      for (int k = 0; k < AVG_DEPTH; k++) avg_hist[k] <= '0;
`endif
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        WAIT_FIRST: begin
          if (rise_pulse) begin
            state <= MEASURE;
          end else if (at_timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
          end
        end
        MEASURE: begin
          if (rise_pulse) begin
`ifdef CLKMON_AVG_EN
            acc_q       <= acc_sum;
            avg_hist[0] <= cnt;
            for (int k = 1; k < AVG_DEPTH; k++) avg_hist[k] <= avg_hist[k-1];
            if (cap_cnt != CAP_W'(AVG_DEPTH)) cap_cnt <= cap_cnt + CAP_W'(1);
            if (cap_cnt >= CAP_W'(AVG_DEPTH - 1)) begin
              period       <= CNT_W'(acc_sum >> AVG_SHIFT);
              period_valid <= 1'b1;
            end
`else
            period       <= cnt;
            period_valid <= 1'b1;
`endif
          end else if (at_timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
          end
          if (fall_pulse) high_time <= cnt;
        end
        LOST: begin
          // The interval ending on this rise began before the loss, so it is
          // a restart and is not reported.
          if (rise_pulse) begin
            state    <= MEASURE;
            clk_lost <= 1'b0;
          end
        end
        default: state <= WAIT_FIRST;
      endcase
`ifdef CLKMON_AVG_EN
      // Outside MEASURE the window is kept empty, so averaging restarts cleanly
      // after reset or a loss of clock.
      if (state != MEASURE) begin
        acc_q   <= '0;
        cap_cnt <= '0;
        for (int k = 0; k < AVG_DEPTH; k++) avg_hist[k] <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: two instances (default and short
// TIMEOUT) compared every cycle against an interval-based reference model.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int TMO [2] = '{65535, 100};

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  logic clk_in = 1'b0;

  logic [1:0]       rp, fp, pv, lost;
  logic [CNT_W-1:0] per [2];
  logic [CNT_W-1:0] ht  [2];

  always #5 mclk = ~mclk;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut0 (
    .mclk(mclk), .rst_n(rst_n), .clk_in(clk_in),
    .rise_pulse(rp[0]), .fall_pulse(fp[0]), .period(per[0]), .high_time(ht[0]),
    .period_valid(pv[0]), .clk_lost(lost[0])
  );

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(16'd100)) dut1 (
    .mclk(mclk), .rst_n(rst_n), .clk_in(clk_in),
    .rise_pulse(rp[1]), .fall_pulse(fp[1]), .period(per[1]), .high_time(ht[1]),
    .period_valid(pv[1]), .clk_lost(lost[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: works on the per-cycle level history of clk_in and on
  // time distances between observed edges.
  bit lvq[$];
  int e;
  bit m_rp, m_fp;
  bit meas [2];
  bit m_lost [2];
  bit m_pv [2];
  int last_rise [2];
  int m_per [2];
  int m_ht [2];
  int raw [2][$];
  int vcnt [2];
  int rcnt [2];
  int lcnt [2];

  function automatic bit lv(input int k);
    return (k < 1) ? 1'b0 : lvq[k-1];
  endfunction

  task automatic model_reset();
    lvq.delete();
    e = 0;
    m_rp = 1'b0;
    m_fp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      meas[i] = 1'b0; m_lost[i] = 1'b0; m_pv[i] = 1'b0;
      last_rise[i] = 0; m_per[i] = 0; m_ht[i] = 0;
      raw[i].delete();
      vcnt[i] = 0; rcnt[i] = 0; lcnt[i] = 0;
    end
  endtask

  task automatic capture(input int i, input int p);
`ifdef CLKMON_AVG_EN
    int s;
    raw[i].push_back(p);
    if (raw[i].size() >= 4) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += raw[i][raw[i].size()-1-k];
      m_per[i] = s >> 2;
      m_pv[i] = 1'b1;
    end
`else
    m_per[i] = p;
    m_pv[i] = 1'b1;
`endif
  endtask

  task automatic model_step();
    bit prp, pfp;
    prp = m_rp;
    pfp = m_fp;
    e++;
    m_rp = lv(e - SYNC) & ~lv(e - SYNC - 1);
    m_fp = ~lv(e - SYNC) & lv(e - SYNC - 1);
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = 1'b0;
      if (prp) begin
        if (meas[i]) capture(i, (e - 1) - last_rise[i]);
        else raw[i].delete();
        meas[i] = 1'b1;
        m_lost[i] = 1'b0;
        last_rise[i] = e - 1;
      end else begin
        if (pfp && meas[i]) m_ht[i] = (e - 1) - last_rise[i];
        if (!m_lost[i] && ((e - 1) - last_rise[i]) >= TMO[i]) begin
          m_lost[i] = 1'b1;
          meas[i] = 1'b0;
          raw[i].delete();
        end
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge mclk) begin
    if (rst_n) begin
      lvq.push_back(clk_in);
      model_step();
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rise_pulse", i, rp[i], m_rp);
      check("fall_pulse", i, fp[i], m_fp);
      check("period", i, per[i], m_per[i]);
      check("high_time", i, ht[i], m_ht[i]);
      check("period_valid", i, pv[i], m_pv[i]);
      check("clk_lost", i, lost[i], m_lost[i]);
      if (rst_n) begin
        vcnt[i] += int'(pv[i]);
        rcnt[i] += int'(rp[i]);
        lcnt[i] += int'(lost[i]);
      end
    end
  end

  task automatic run_clk(input int hi, input int lo, input int n);
    repeat (n) begin
      clk_in = 1'b1;
      repeat (hi) @(negedge mclk);
      clk_in = 1'b0;
      repeat (lo) @(negedge mclk);
    end
  endtask

  task automatic idle_low(input int n);
    clk_in = 1'b0;
    repeat (n) @(negedge mclk);
  endtask

  int v_before, l_before;

  initial begin
    model_reset();
    rst_n  = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge mclk);
    check("reset_period", 0, per[0], 0);
    check("reset_lost", 1, lost[1], 0);
    rst_n = 1'b1;

    // mclk/8, 50% duty
    run_clk(4, 4, 10);
    idle_low(6);
    check("div8_period", 0, per[0], 8);
    check("div8_high", 0, ht[0], 4);
    check("div8_model_period", 0, m_per[0], 8);
    check("div8_rises", 0, rcnt[0], 10);
    check("div8_valids", 0, vcnt[0], 9);
    check("div8_period_t100", 1, per[1], 8);

    // mclk/512
    run_clk(256, 256, 3);
    idle_low(6);
    check("div512_period", 0, per[0], 512);
    check("div512_high", 0, ht[0], 256);
    check("div512_lost_t100", 1, lost[1], 1);

    // Loss of clock and restart on the short-timeout instance
    run_clk(4, 4, 5);
    idle_low(120);
    check("lost_flag", 1, lost[1], 1);
    check("lost_period_hold", 1, per[1], 8);
    v_before = vcnt[1];
    run_clk(4, 4, 3);
    idle_low(6);
    check("restart_valids", 1, vcnt[1] - v_before, 2);
    check("restart_period", 1, per[1], 8);
    check("restart_lost_clear", 1, lost[1], 0);

    // Duty change 3 high / 5 low
    run_clk(3, 5, 6);
    idle_low(6);
    check("duty_high", 0, ht[0], 3);
    check("duty_period", 0, per[0], 8);

    // Interval exactly TIMEOUT: rise wins, no loss
    run_clk(50, 50, 3);
    check("tmo_exact_period", 1, per[1], 100);
    check("tmo_exact_lost", 1, lost[1], 0);
    // Interval TIMEOUT+1: one cycle of loss, period holds
    l_before = lcnt[1];
    run_clk(50, 51, 2);
    check("tmo_plus1_period", 1, per[1], 100);
    check("tmo_plus1_lost_cycles", 1, lcnt[1] - l_before, 1);

    // Reset mid-period with clk_in high; stale synchronizer content discarded
    run_clk(4, 4, 2);
    clk_in = 1'b1;
    repeat (2) @(negedge mclk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_period", 0, per[0], 0);
    check("midrst_high", 0, ht[0], 0);
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    idle_low(4);
    run_clk(4, 4, 3);
    idle_low(6);
    check("midrst_rises", 0, rcnt[0], 4);
    check("midrst_valids", 0, vcnt[0], 3);

    // Randomized shapes, with occasional gaps around the short timeout
    repeat (40) begin
      run_clk($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) idle_low($urandom_range(90, 130));
    end
    idle_low(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
